dawncarol_led_pattern: RTL and testbench



---
 rtl/dawncarol_led_pkg.sv | 22 ++
 rtl/dawncarol_led_tick.sv | 44 ++++
 rtl/dawncarol_led_pattern.sv | 99 +++++++++
 tb/tb_dawncarol_led_pattern.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dawncarol_led_pkg.sv
// Shared types for the LED pattern generator: pattern select, FSM states and the
// reset-time step period.
package dawncarol_led_pkg;

  typedef enum logic [1:0] {
    ROT_R  = 2'd0,
    ROT_L  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } led_mode_e;

  typedef enum logic [2:0] {
    S_ROT_R,
    S_ROT_L,
    S_BNC_UP,
    S_BNC_DN,
    S_BLINK
  } led_state_e;

  localparam logic [31:0] DefPeriod = 32'd49_999_999;

endpackage

// File: rtl/dawncarol_led_tick.sv
// Step-rate divider: counts running cycles and flags a tick once the count reaches the
// latched period.
module dawncarol_led_tick #(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             expired;

  // >= rather than == so a shrunk period never has to wrap the counter
  assign expired = (cnt_q >= period_q);
  assign tick    = run & expired;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (cfg_load) begin
      cnt_d    = '0;
      period_d = period;
    end else if (run) begin
      cnt_d = expired ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= DEF_PERIOD;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/dawncarol_led_pattern.sv
// LED pattern generator top: pattern FSM, LED register and step strobe, advanced by the
// tick divider.
module dawncarol_led_pattern
  import dawncarol_led_pkg::*;
#(
  parameter int unsigned      LED_NUM    = 4,
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(DefPeriod)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               cfg_load,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  output logic [LED_NUM-1:0] led,
  output logic               step,
  output logic [1:0]         cur_mode
);

  localparam logic [LED_NUM-1:0] LedOne = {{(LED_NUM-1){1'b0}}, 1'b1};

  led_state_e         state_q, state_d;
  led_mode_e          mode_q, mode_d;
  logic [LED_NUM-1:0] led_q, led_d;
  logic               step_q, step_d;
  logic               tick;

  dawncarol_led_tick #(
    .CNT_W      (CNT_W),
    .DEF_PERIOD (DEF_PERIOD)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .cfg_load (cfg_load),
    .period   (period),
    .tick     (tick)
  );

  // cfg_load has priority, so a tick landing on the same cycle is dropped
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    led_d   = led_q;
    step_d  = 1'b0;
    if (cfg_load) begin
      mode_d = led_mode_e'(mode);
      led_d  = LedOne;
      case (led_mode_e'(mode))
        ROT_R:   state_d = S_ROT_R;
        ROT_L:   state_d = S_ROT_L;
        BOUNCE:  state_d = S_BNC_UP;
        default: begin
          state_d = S_BLINK;
          led_d   = '1;
        end
      endcase
    end else if (tick) begin
      step_d = 1'b1;
      case (state_q)
        S_ROT_R:  led_d = {led_q[0], led_q[LED_NUM-1:1]};
        S_ROT_L:  led_d = {led_q[LED_NUM-2:0], led_q[LED_NUM-1]};
        S_BNC_UP: begin
          led_d = led_q << 1;
          if (led_d[LED_NUM-1]) state_d = S_BNC_DN;
        end
        S_BNC_DN: begin
          led_d = led_q >> 1;
          if (led_d[0]) state_d = S_BNC_UP;
        end
        S_BLINK:  led_d = ~led_q;
        default: begin
          state_d = S_ROT_R;
          led_d   = LedOne;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ROT_R;
      mode_q  <= ROT_R;
      led_q   <= LedOne;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign led      = led_q;
  assign step     = step_q;
  assign cur_mode = mode_q;

endmodule

// File: tb/tb_dawncarol_led_pattern.sv
// Bench for dawncarol_led_pattern: 4-LED and 8-LED instances share stimulus and are
// checked against a step-index model of each pattern.
module tb_dawncarol_led_pattern;

  logic        clk;
  logic        reset;
  logic        run;
  logic        cfg_load;
  logic [1:0]  mode;
  logic [31:0] period;
  logic [3:0]  led4;
  logic [7:0]  led8;
  logic        step4, step8;
  logic [1:0]  cur_mode4, cur_mode8;

  int n_cmp = 0;
  int n_err = 0;

  // Model: latched mode/period, step index since last load/reset, running cycles since
  // the last step.
  logic [1:0] m_mode;
  longint     m_p;
  int         m_k;
  longint     m_el;
  bit         m_step;

  dawncarol_led_pattern #(
    .LED_NUM    (4),
    .CNT_W      (32),
    .DEF_PERIOD (32'd3)
  ) u_dut4 (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .cfg_load (cfg_load),
    .mode     (mode),
    .period   (period),
    .led      (led4),
    .step     (step4),
    .cur_mode (cur_mode4)
  );

  dawncarol_led_pattern #(
    .LED_NUM    (8),
    .CNT_W      (32),
    .DEF_PERIOD (32'd3)
  ) u_dut8 (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .cfg_load (cfg_load),
    .mode     (mode),
    .period   (period),
    .led      (led8),
    .step     (step8),
    .cur_mode (cur_mode8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LED value k steps after a pattern's entry point, for an n-LED bank
  function automatic logic [7:0] exp_led(int n, logic [1:0] md, int k);
    logic [7:0] one;
    logic [7:0] mask;
    int pos;
    one  = 8'd1;
    mask = 8'((1 << n) - 1);
    pos  = 0;
    case (md)
      2'd0: pos = (n - (k % n)) % n;
      2'd1: pos = k % n;
      2'd2: begin
        pos = k % (2 * n - 2);
        if (pos >= n) pos = 2 * n - 2 - pos;
      end
      default: pos = 0;
    endcase
    if (md == 2'd3) return (k % 2 == 0) ? mask : 8'h00;
    return one << pos;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".led4"}, {4'h0, led4}, exp_led(4, m_mode, m_k));
    chk({tag, ".led8"}, led8, exp_led(8, m_mode, m_k));
    chk({tag, ".step4"}, {7'h0, step4}, {7'h0, m_step});
    chk({tag, ".step8"}, {7'h0, step8}, {7'h0, m_step});
    chk({tag, ".mode4"}, {6'h0, cur_mode4}, {6'h0, m_mode});
    chk({tag, ".mode8"}, {6'h0, cur_mode8}, {6'h0, m_mode});
  endtask

  task automatic model_reset();
    m_mode = 2'd0;
    m_p    = 3;
    m_k    = 0;
    m_el   = 0;
    m_step = 1'b0;
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it
  task automatic cyc(input string tag, input bit r, input bit ld, input logic [1:0] md,
                     input logic [31:0] p);
    run      = r;
    cfg_load = ld;
    mode     = md;
    period   = p;
    @(posedge clk);
    m_step = 1'b0;
    if (ld) begin
      m_mode = md;
      m_p    = longint'(p);
      m_k    = 0;
      m_el   = 0;
    end else if (r) begin
      m_el++;
      if (m_el == m_p + 1) begin
        m_k++;
        m_el   = 0;
        m_step = 1'b1;
      end
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    bit         r, ld;
    logic [1:0] md;
    logic [31:0] p;

    reset    = 1'b1;
    run      = 1'b0;
    cfg_load = 1'b0;
    mode     = 2'd0;
    period   = 32'd0;
    model_reset();
    #12;
    chk_all("reset");
    reset = 1'b0;

    // Reset-default rotate right, period 3
    for (int i = 0; i < 17; i++) cyc("defrun", 1'b1, 1'b0, 2'd0, 32'd0);

    // Bounce at one step per cycle
    cyc("bnc_load", 1'b1, 1'b1, 2'd2, 32'd0);
    for (int i = 0; i < 8; i++) cyc("bnc", 1'b1, 1'b0, 2'd2, 32'd0);

    // ROT_L period 2, pause mid-count, resume
    cyc("rotl_load", 1'b1, 1'b1, 2'd1, 32'd2);
    cyc("rotl_run", 1'b1, 1'b0, 2'd1, 32'd2);
    for (int i = 0; i < 10; i++) cyc("pause", 1'b0, 1'b0, 2'd1, 32'd2);
    for (int i = 0; i < 7; i++) cyc("resume", 1'b1, 1'b0, 2'd1, 32'd2);

    // Load blink while paused
    cyc("blink_paused", 1'b0, 1'b1, 2'd3, 32'd7);
    cyc("paused_hold", 1'b0, 1'b0, 2'd3, 32'd7);

    // Period shrink: counter at 40 with P=100, then reload with P=5
    cyc("p100_load", 1'b1, 1'b1, 2'd0, 32'd100);
    for (int i = 0; i < 40; i++) cyc("p100", 1'b1, 1'b0, 2'd0, 32'd100);
    cyc("p5_load", 1'b1, 1'b1, 2'd0, 32'd5);
    for (int i = 0; i < 8; i++) cyc("p5", 1'b1, 1'b0, 2'd0, 32'd5);

    // cfg_load on the cycle a tick is due
    cyc("coll_setup", 1'b1, 1'b1, 2'd1, 32'd3);
    for (int i = 0; i < 3; i++) cyc("coll_cnt", 1'b1, 1'b0, 2'd1, 32'd3);
    cyc("coll_load", 1'b1, 1'b1, 2'd2, 32'd3);
    for (int i = 0; i < 5; i++) cyc("coll_after", 1'b1, 1'b0, 2'd2, 32'd3);

    // Blink period 1 (8-LED instance alternates FF/00)
    cyc("blink_load", 1'b1, 1'b1, 2'd3, 32'd1);
    for (int i = 0; i < 8; i++) cyc("blink", 1'b1, 1'b0, 2'd3, 32'd1);

    // Asynchronous reset while bouncing downward
    cyc("bdn_load", 1'b1, 1'b1, 2'd2, 32'd0);
    for (int i = 0; i < 4; i++) cyc("bdn", 1'b1, 1'b0, 2'd2, 32'd0);
    chk("bdn_reached_dn", {4'h0, led4}, 8'h04);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk_all("async_reset");
    reset = 1'b0;
    for (int i = 0; i < 10; i++) cyc("after_reset", 1'b1, 1'b0, 2'd2, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 19) == 0);
      md = 2'($urandom_range(0, 3));
      p  = 32'($urandom_range(0, 5));
      cyc("rand", r, ld, md, p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
